// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared constants, state type and ID width helper for adder_arbiter
package adder_arb_pkg;
    localparam int ADDER_W = 64;
    localparam int DEF_NUM_REQ = 4;
    typedef enum logic {EMPTY, FULL} out_state_e;
    function automatic int id_w(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/adder64.sv
// adder64: 64-bit block carry-lookahead adder, 4-bit lookahead groups chained by group carry
module adder64
    import adder_arb_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);
    localparam int NG = ADDER_W / 4;
    logic [ADDER_W-1:0] p, g, c;
    logic [NG-1:0] gp, gg;
    logic [NG:0] gc;
    assign p = a ^ b;
    assign g = a & b;
    for (genvar i = 0; i < NG; i++) begin : grp
        logic [3:0] pi, gi;
        logic ci;
        assign pi = p[4*i +: 4];
        assign gi = g[4*i +: 4];
        assign ci = gc[i];
        assign gp[i] = &pi;
        assign gg[i] = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
        assign c[4*i]     = ci;
        assign c[4*i + 1] = gi[0] | (pi[0] & ci);
        assign c[4*i + 2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
        assign c[4*i + 3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    end
    always_comb begin
        gc[0] = cin;
        for (int k = 0; k < NG; k++) gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    assign sum = p ^ c;
    assign cout = gc[NG];
endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// rr_arbiter: picks the first set request at or above ptr with wrap-around; gnt gated by en
module rr_arbiter #(
    parameter int N = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx = IW'((int'(ptr) + k) % N);
                any = 1'b1;
            end
        end
        gnt = (any && en) ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one adder64 with a registered valid/ready result stage
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int WIDTH = ADDER_W,
    localparam int ID_W = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_cin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic [ID_W-1:0]          rsp_id
);
    out_state_e state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, gidx;
    logic gany, can_accept, accept, add_carry;
    logic [WIDTH-1:0] op_a, op_b, add_sum;
    assign rsp_valid = state_q == FULL;
    assign can_accept = !rsp_valid || rsp_ready;
    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .req(req_valid),
        .ptr(ptr_q),
        .en(can_accept && rst_n),
        .gnt(req_ready),
        .idx(gidx),
        .any(gany)
    );
    assign accept = gany && can_accept && rst_n;
    assign op_a = req_a[gidx*WIDTH +: WIDTH];
    assign op_b = req_b[gidx*WIDTH +: WIDTH];
    adder64 u_add (
        .a(op_a),
        .b(op_b),
        .cin(req_cin[gidx]),
        .sum(add_sum),
        .cout(add_carry)
    );
    always_comb begin
        state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
        ptr_d = !accept ? ptr_q : (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q <= '0;
            rsp_sum <= '0;
            rsp_carry <= 1'b0;
            rsp_id <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            if (accept) begin
                rsp_sum <= add_sum;
                rsp_carry <= add_carry;
                rsp_id <= gidx;
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks of adder_arbiter against a round-robin reference model
module tb_adder_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic [N-1:0] req_cin = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [W-1:0] rsp_sum;
    logic rsp_carry;
    logic [1:0] rsp_id;
    int checks = 0;
    int errors = 0;
    bit m_valid = 1'b0;
    logic [W-1:0] m_sum = '0;
    bit m_carry = 1'b0;
    int m_id = 0;
    int m_ptr = 0;
    logic [W-1:0] held_sum;

    adder_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i] = c;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_sum = '0;
        m_carry = 1'b0;
        m_id = 0;
        m_ptr = 0;
    endtask

    // Called at a falling edge with inputs settled; checks, then advances the model over one rising edge.
    task automatic cycle();
        int g;
        bit acc, rr;
        logic [64:0] s;
        logic [N-1:0] er;
        #1;
        g = pick();
        rr = rsp_ready;
        acc = rst_n && (!m_valid || rr) && g >= 0;
        er = acc ? N'(1) << g : '0;
        s = '0;
        if (acc) s = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]} + 65'(req_cin[g]);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        chk("rsp_sum", rsp_sum, m_sum);
        chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        @(posedge clk);
        if (acc) begin
            m_valid = 1'b1;
            m_sum = s[63:0];
            m_carry = s[64];
            m_id = g;
            m_ptr = (g + 1) % N;
        end else if (rr) m_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid_now", 64'(rsp_valid), 64'd0);
        chk("rst_ready_now", 64'(req_ready), 64'd0);
        model_reset();
        @(negedge clk);
        chk("rst_sum", rsp_sum, 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        chk("init_valid", 64'(rsp_valid), 64'd0);
        chk("init_sum", rsp_sum, 64'd0);
        chk("init_carry", 64'(rsp_carry), 64'd0);
        chk("init_id", 64'(rsp_id), 64'd0);
        chk("init_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // overflow through requester 1, left stalled in the result register
        set_req(1, '1, 64'd1, 1'b0);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        cycle();
        chk("t2_valid", 64'(rsp_valid), 64'd1);
        chk("t2_sum", rsp_sum, 64'd0);
        chk("t2_carry", 64'(rsp_carry), 64'd1);
        chk("t2_id", 64'(rsp_id), 64'd1);
        for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        req_valid = 4'b1111;
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_valid", 64'(rsp_valid), 64'd1);
            chk("t3_id", 64'(rsp_id), 64'(i % N));
        end
        rsp_ready = 1'b0;
        held_sum = rsp_sum;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_hold_id", 64'(rsp_id), 64'd0);
            chk("t4_hold_sum", rsp_sum, held_sum);
        end
        rsp_ready = 1'b1;
        cycle();
        chk("t4_resume_id", 64'(rsp_id), 64'd1);
        req_valid = '0;
        cycle();
        chk("drain_valid", 64'(rsp_valid), 64'd0);
        set_req(2, 64'd5, 64'd7, 1'b1);
        req_valid = 4'b0100;
        cycle();
        chk("t5a_sum", rsp_sum, 64'd13);
        chk("t5a_carry", 64'(rsp_carry), 64'd0);
        chk("t5a_id", 64'(rsp_id), 64'd2);
        set_req(3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        req_valid = 4'b1000;
        cycle();
        chk("t5b_sum", rsp_sum, 64'd0);
        chk("t5b_carry", 64'(rsp_carry), 64'd1);
        chk("t5b_id", 64'(rsp_id), 64'd3);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        cycle();
        chk("t6_id", 64'(rsp_id), 64'd2);
        req_valid = '0;
        cycle();
        chk("t6_no_spurious", 64'(rsp_valid), 64'd0);
        chk("t6_last_id", 64'(rsp_id), 64'd2);
        for (int n = 0; n < 400; n++) begin
            req_valid = N'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0: set_req(i, '1, {63'd0, 1'($urandom)}, 1'($urandom));
                    1: set_req(i, 64'(1) << $urandom_range(0, 63), 64'(1) << $urandom_range(0, 63), 1'($urandom));
                    default: set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
                endcase
            end
            if (n == 200) do_reset();
            else cycle();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
